// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a two-entry skid buffer.
// The main entry drives the outputs directly. The skid entry catches the one
// beat that can arrive in the same cycle that back-pressure appears. Because of
// this, o_Ready comes from a flop and does not depend on i_Ready
// combinationally. The block also has a flush (with optional payload zeroing),
// an occupancy output, and a saturating stall-cycle counter.
module pipe_skid_stage #(
    parameter int PAYLOAD_WIDTH = 128,
    parameter int FLUSH_ZERO    = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_Flush,
    input  logic                     i_Valid,
    output logic                     o_Ready,
    input  logic [PAYLOAD_WIDTH-1:0] i_Payload,
    output logic                     o_Valid,
    input  logic                     i_Ready,
    output logic [PAYLOAD_WIDTH-1:0] o_Payload,
    output logic [1:0]               o_Occupancy,
    input  logic                     i_Clear_Count,
    output logic [CNT_WIDTH-1:0]     o_Stall_Cycles
);

    typedef struct packed {
        logic                     v;
        logic [PAYLOAD_WIDTH-1:0] d;
    } entry_t;

    // Occupancy states. Each state is decoded from the two valid flops,
    // so the FSM needs no separate state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    entry_t                 main_q;
    entry_t                 skid_q;
    occ_state_t             state;
    logic                   in_xfer;
    logic                   out_xfer;
    logic [CNT_WIDTH-1:0]   stall_cnt;

    assign o_Ready        = ~skid_q.v;
    assign o_Valid        = main_q.v;
    assign o_Payload      = main_q.d;
    assign o_Occupancy    = {skid_q.v, main_q.v ^ skid_q.v};
    assign o_Stall_Cycles = stall_cnt;

    assign in_xfer  = i_Valid & o_Ready;
    assign out_xfer = o_Valid & i_Ready;

    // Decode the occupancy state from the valid bits. The pattern skid-only
    // cannot occur; it maps to EMPTY so the stage holds until a flush or reset.
    always_comb begin
        state = EMPTY;
        case ({skid_q.v, main_q.v})
            2'b01:   state = HALF;
            2'b11:   state = FULL;
            default: state = EMPTY;
        endcase
    end

    // Entry storage. Flush overrides every handshake. In FULL there is no
    // capture (o_Ready is low), so promoting skid to main never collides with
    // a new beat.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (i_Flush) begin
            main_q.v <= 1'b0;
            skid_q.v <= 1'b0;
            if (FLUSH_ZERO != 0) begin
                main_q.d <= '0;
                skid_q.d <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_q.v <= 1'b1;
                        main_q.d <= i_Payload;
                    end
                end
                HALF: begin
                    if (in_xfer && out_xfer) begin
                        main_q.d <= i_Payload;
                    end else if (in_xfer) begin
                        skid_q.v <= 1'b1;
                        skid_q.d <= i_Payload;
                    end else if (out_xfer) begin
                        main_q.v <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_q.d <= skid_q.d;
                        skid_q.v <= 1'b0;
                    end
                end
                default: begin
                    main_q <= main_q;
                end
            endcase
        end
    end

    // Count the cycles in which downstream back-pressure stalls a valid beat.
    // A clear takes priority over an increment. A flush cycle does not count.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            stall_cnt <= '0;
        end else if (i_Clear_Count) begin
            stall_cnt <= '0;
        end else if (o_Valid && !i_Ready && !i_Flush && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
